// File: rtl/direction_scoring_nway.sv
// Per-car SCAN direction controller; all outputs registered, 1-cycle latency from inputs.
// DIR_SCORE_WEIGHTED_EN: destinations weigh 2 and hall requests 1 in the up/down scores.
module direction_scoring_nway #(
    parameter int NUM_CARS     = 2,
    parameter int NUM_FLOORS   = 6,
    parameter int DWELL_CYCLES = 4,
    localparam int POS_W       = $clog2(2*NUM_FLOORS),
    localparam int FLOOR_W     = $clog2(NUM_FLOORS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CARS*NUM_FLOORS-1:0] floor_destinations,
    input  logic [NUM_CARS*NUM_FLOORS-1:0] floors_requested,
    input  logic [NUM_CARS*POS_W-1:0]      half_positions,
    output logic [NUM_CARS-1:0]            directions,
    output logic [NUM_CARS-1:0]            moving,
    output logic [NUM_CARS-1:0]            arrive,
    output logic [NUM_CARS*FLOOR_W-1:0]    arrive_floor
);
    localparam int SW    = FLOOR_W + 2;
    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN, S_DWELL} state_t;

    for (genvar c = 0; c < NUM_CARS; c++) begin : g_car
        logic [NUM_FLOORS-1:0] w_dest, w_req, w_tgt, w_above, w_below;
        logic [POS_W-1:0]      w_pos;
        logic [SW-1:0]         w_score_up, w_score_dn;
        logic                  w_at, w_oor, w_expire, w_enter_dwell;
        int                    w_dist_up, w_dist_dn;
        state_t                r_state, w_next;
        logic [CNT_W-1:0]      r_cnt;
        logic                  r_dir, r_mov, r_arr;
        logic [FLOOR_W-1:0]    r_afl;

        assign w_dest = floor_destinations[c*NUM_FLOORS +: NUM_FLOORS];
        assign w_req  = floors_requested[c*NUM_FLOORS +: NUM_FLOORS];
        assign w_pos  = half_positions[c*POS_W +: POS_W];
        assign w_tgt  = w_dest | w_req;
        assign w_oor  = int'(w_pos) > 2*(NUM_FLOORS-1);

        always_comb begin
            w_above    = '0;
            w_below    = '0;
            w_at       = 1'b0;
            w_score_up = '0;
            w_score_dn = '0;
            w_dist_up  = 2*NUM_FLOORS;
            w_dist_dn  = 2*NUM_FLOORS;
            for (int f = 0; f < NUM_FLOORS; f++) begin
                if (w_tgt[f]) begin
                    if (2*f > int'(w_pos)) begin
                        w_above[f] = 1'b1;
`ifdef DIR_SCORE_WEIGHTED_EN
                        w_score_up = w_score_up + (w_dest[f] ? SW'(2) : SW'(1));
`else
                        w_score_up = w_score_up + SW'(1);
`endif
                        if (2*f - int'(w_pos) < w_dist_up) w_dist_up = 2*f - int'(w_pos);
                    end else if (2*f < int'(w_pos)) begin
                        w_below[f] = 1'b1;
`ifdef DIR_SCORE_WEIGHTED_EN
                        w_score_dn = w_score_dn + (w_dest[f] ? SW'(2) : SW'(1));
`else
                        w_score_dn = w_score_dn + SW'(1);
`endif
                        if (int'(w_pos) - 2*f < w_dist_dn) w_dist_dn = int'(w_pos) - 2*f;
                    end else begin
                        w_at = 1'b1;
                    end
                end
            end
        end

        assign w_expire = (r_cnt == CNT_W'(DWELL_CYCLES-1));

        always_comb begin
            w_next = r_state;
            case (r_state)
                S_IDLE: begin
                    if (w_at) w_next = S_DWELL;
                    else if (|w_above || |w_below) begin
                        if (w_score_up > w_score_dn)      w_next = S_UP;
                        else if (w_score_up < w_score_dn) w_next = S_DOWN;
                        else w_next = (w_dist_up <= w_dist_dn) ? S_UP : S_DOWN;
                    end
                end
                // Between floors the car keeps its heading until the next floor.
                S_UP: begin
                    if (w_at)            w_next = S_DWELL;
                    else if (|w_above)   w_next = S_UP;
                    else if (!w_pos[0])  w_next = (|w_below) ? S_DOWN : S_IDLE;
                end
                S_DOWN: begin
                    if (w_at)            w_next = S_DWELL;
                    else if (|w_below)   w_next = S_DOWN;
                    else if (!w_pos[0])  w_next = (|w_above) ? S_UP : S_IDLE;
                end
                S_DWELL: begin
                    if (w_expire) begin
                        if (r_dir ? |w_above : |w_below)      w_next = r_dir ? S_UP : S_DOWN;
                        else if (r_dir ? |w_below : |w_above) w_next = r_dir ? S_DOWN : S_UP;
                        else                                  w_next = S_IDLE;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end

        assign w_enter_dwell = (w_next == S_DWELL) && (r_state != S_DWELL);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_dir   <= 1'b0;
                r_mov   <= 1'b0;
                r_arr   <= 1'b0;
                r_afl   <= '0;
            end else if (w_oor) begin
                r_arr <= 1'b0;
            end else begin
                r_state <= w_next;
                r_arr   <= w_enter_dwell;
                r_mov   <= (w_next == S_UP) || (w_next == S_DOWN);
                if (w_enter_dwell)          r_afl <= w_pos[POS_W-1:1];
                if (w_next == S_UP)         r_dir <= 1'b1;
                else if (w_next == S_DOWN)  r_dir <= 1'b0;
                if ((r_state == S_DWELL) && !w_expire) r_cnt <= r_cnt + CNT_W'(1);
                else                                   r_cnt <= '0;
            end
        end

        assign directions[c]                     = r_dir;
        assign moving[c]                         = r_mov;
        assign arrive[c]                         = r_arr;
        assign arrive_floor[c*FLOOR_W +: FLOOR_W] = r_afl;
    end
endmodule

// File: doc/direction_scoring_nway.md
# direction_scoring_nway

Parametrised per-car direction controller for the elevator ASIC, successor to the fixed two-car, six-floor direction scorer. For each of NUM_CARS cars it combines in-car destinations and hall requests with the car's half-floor position. A registered SCAN-style state machine (IDLE/UP/DOWN/DWELL) then produces travel direction, a moving flag and a one-cycle arrival pulse carrying the served floor. It sits between the request-latch logic, which consumes the arrival pulses to clear served targets, and the motor/display drivers.

## Interface
- NUM_CARS, 2, number of independent cars
- NUM_FLOORS, 6, floors per car (≥2)
- DWELL_CYCLES, 4, cycles a car holds at a served floor (≥1)
- POS_W, $clog2(2*NUM_FLOORS), half-floor position width (derived, do not override)
- FLOOR_W, $clog2(NUM_FLOORS), floor index width (derived)

- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- floor_destinations  in  NUM_CARS*NUM_FLOORS  in-car targets; bits [c*NUM_FLOORS +: NUM_FLOORS] belong to car c, bit f = floor f
- floors_requested  in  NUM_CARS*NUM_FLOORS  hall requests assigned to each car, same packing
- half_positions  in  NUM_CARS*POS_W  car c position at [c*POS_W +: POS_W]; even value 2f = at floor f, odd value = between floors
- directions  out  NUM_CARS  1 = up, 0 = down (MSB = highest car index)
- moving  out  NUM_CARS  car in UP or DOWN state
- arrive  out  NUM_CARS  one-cycle pulse on entry to DWELL
- arrive_floor  out  NUM_CARS*FLOOR_W  floor served, valid while arrive high, held otherwise

## Operation
- Per car, combinationally: T = destinations | requests.
  - above = T bits f with 2f > pos; below = T bits f with 2f < pos.
  - at = pos even and T[pos/2].
- Score: score_up and score_down are weighted counts over above and below (see Configuration). Counter width is FLOOR_W+2 and must not overflow.
- IDLE:
  - at → DWELL.
  - Else if above or below is nonzero → UP if score_up > score_down, DOWN if score_up < score_down.
  - On a score tie, pick the direction of the nearest target (distance in half-floors); equal distance → UP.
  - Else stay IDLE.
- UP:
  - at → DWELL.
  - Else if above is nonzero → stay UP.
  - Else, at an even pos: below nonzero → DOWN, otherwise IDLE.
  - Else, at an odd pos: stay UP until the next even position. No mid-span reversal.
- DOWN: mirror of UP.
- DWELL:
  - moving = 0, directions held, counter counts DWELL_CYCLES.
  - On expiry, `at` is ignored. Targets ahead in the held direction → continue; else targets behind → reverse; else IDLE.
- Direction register updates only on entry to UP or DOWN. IDLE and DWELL hold the last value.
- Out-of-range position (pos > 2*(NUM_FLOORS-1)): the car holds state, counter and outputs; arrive is forced 0.
- Cars are fully independent; there are no cross-car interactions.

## Timing
- Inputs are sampled at edge k; state and outputs update at edge k. All outputs are registered, giving 1-cycle latency from input change to output.
- Reset: state IDLE, directions 0, moving 0, arrive 0, arrive_floor 0, dwell counter 0.
- Reset has priority over all transitions, including mid-DWELL; no arrive pulse is issued on the reset edge.
- arrive is high for exactly one cycle per DWELL entry. arrive_floor = pos/2 is latched at the same edge.
- DWELL lasts exactly DWELL_CYCLES cycles with moving = 0. The next state is visible on the cycle after the last dwell cycle.
- Targets may change in any cycle. Upstream clearing a target during DWELL has no effect until expiry.

## Configuration
- DIR_SCORE_WEIGHTED_EN defined: each destination bit counts 2 and each request bit counts 1. A floor set in both counts 2, not 3.
- Not defined: every bit of T counts 1.

## Test plan
All scenarios use NUM_CARS=2, NUM_FLOORS=6, DWELL_CYCLES=4.
- Reset: rst high for 2 cycles with all targets set → all outputs 0; after release, car 0 at pos 0 with dest floor 3 shows directions[0]=1, moving[0]=1 one cycle later.
- Trip: car 0 dest floor 3, pos stepped 0..6 → arrive[0] one cycle at pos 6 with arrive_floor=3; moving[0]=0 for 4 cycles; IDLE once the target is cleared.
- Scoring: car 1 at pos 6, dests floors 4 and 5, requests floors 0, 1, 2.
  - Macro defined → UP (4 vs 3).
  - Macro undefined → DOWN (2 vs 3).
- Hysteresis: car 0 UP at pos 3 toward floor 4, request floor 0 added → stays UP, arrives at pos 8, then after dwell DOWN with directions[0]=0.
- Odd hold: car 0 UP at pos 5, above target cleared, target at floor 0 remains → directions[0] stays 1 until pos 6, DOWN the next cycle.
- Boundaries:
  - rst asserted at dwell cycle 2 → IDLE next edge, no arrive.
  - pos=11 (out of range) → car 1 outputs frozen.
